uart_wb_bridge: RTL

UART-to-Wishbone debug bridge. A host on the FTDI serial link issues single 32-bit reads and writes into the SoC address space without CPU involvement. The bridge is the host-driven counterpart of the CPU-side Wishbone master path: it is a classic Wishbone initiator on the SoC bus and a UART responder towards the host. It contains its own 8N1 receiver and transmitter.

---
 rtl/uart_wb_bridge.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge: UART 8N1 host to Wishbone single-word debug bridge; define UART_WB_BRIDGE_TIMEOUT_EN for a bus watchdog
module uart_wb_bridge #(
  parameter int CLK_DIV        = 208,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        busy_o
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);

  if (CLK_DIV < 4 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_wb_bridge: CLK_DIV must be >= 4 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   adr_q, adr_d, dat_q, dat_d;
  logic [39:0]   resp_q, resp_d;
  logic [2:0]    left_q, left_d;
  logic [2:0]    rx_s_q;
  logic [3:0]    rx_bit_q;
  logic [CW-1:0] rx_cnt_q;
  logic [7:0]    rx_sh_q;
  logic [9:0]    tx_sh_q;
  logic [3:0]    tx_bits_q;
  logic [CW-1:0] tx_cnt_q;
  logic          rx_tick, rx_valid, tx_free, tx_load, to_hit;

  // rx_bit_q: 0 idle, 1 start, 2..9 data, 10 stop
  assign rx_tick  = rx_cnt_q == (rx_bit_q == 4'd1 ? HALF : FULL);
  assign rx_valid = rx_bit_q == 4'd10 && rx_tick && rx_s_q[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s_q   <= 3'b111;
      rx_bit_q <= '0;
      rx_cnt_q <= '0;
      rx_sh_q  <= '0;
    end else begin
      rx_s_q <= {rx_s_q[1:0], uart_rx};
      if (rx_bit_q == 4'd0) begin
        rx_cnt_q <= '0;
        if (rx_s_q[2] && !rx_s_q[1]) rx_bit_q <= 4'd1;
      end else if (!rx_tick) begin
        rx_cnt_q <= rx_cnt_q + 1'b1;
      end else begin
        rx_cnt_q <= '0;
        if (rx_bit_q == 4'd1) rx_bit_q <= rx_s_q[1] ? 4'd0 : 4'd2;
        else if (rx_bit_q == 4'd10) rx_bit_q <= 4'd0;
        else begin
          rx_sh_q  <= {rx_s_q[1], rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 4'd1;
        end
      end
    end
  end

  // a new byte may load during the last stop-bit cycle so responses run back-to-back
  assign tx_free = tx_bits_q == 4'd0 || (tx_bits_q == 4'd1 && tx_cnt_q == FULL);
  assign tx_load = state_q == S_RESP && left_q != 3'd0 && tx_free;
  assign uart_tx = (tx_bits_q == 4'd0) | tx_sh_q[0];

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_sh_q   <= '1;
      tx_bits_q <= '0;
      tx_cnt_q  <= '0;
    end else if (tx_load) begin
      tx_sh_q   <= {1'b1, resp_q[39:32], 1'b0};
      tx_bits_q <= 4'd10;
      tx_cnt_q  <= '0;
    end else if (tx_bits_q != 4'd0) begin
      tx_cnt_q <= tx_cnt_q == FULL ? '0 : tx_cnt_q + 1'b1;
      if (tx_cnt_q == FULL) begin
        tx_sh_q   <= {1'b1, tx_sh_q[9:1]};
        tx_bits_q <= tx_bits_q - 4'd1;
      end
    end
  end

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q;
  always_ff @(posedge clock) to_q <= (reset || state_q != S_BUS) ? '0 : to_q + 1'b1;
  assign to_hit = to_q == TW'(TIMEOUT_CYCLES - 1);
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    resp_d  = resp_q;
    left_d  = left_q;
    case (state_q)
      S_IDLE: if (rx_valid && (rx_sh_q == 8'h77 || rx_sh_q == 8'h72)) begin
        state_d = S_ADDR;
        we_d    = rx_sh_q == 8'h77;
      end
      S_ADDR: if (rx_valid) begin
        adr_d = {adr_q[23:0], rx_sh_q};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = we_q ? S_DATA : S_BUS;
      end
      S_DATA: if (rx_valid) begin
        dat_d = {dat_q[23:0], rx_sh_q};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = S_BUS;
      end
      S_BUS: if (wbm_err_i || (to_hit && !wbm_ack_i)) begin
        state_d = S_RESP;
        resp_d  = {8'h45, 32'h0};
        left_d  = 3'd1;
      end else if (wbm_ack_i) begin
        state_d = S_RESP;
        resp_d  = {8'h4B, wbm_dat_i};
        left_d  = we_q ? 3'd1 : 3'd5;
      end
      S_RESP: begin
        if (tx_load) begin
          resp_d = {resp_q[31:0], 8'h00};
          left_d = left_q - 3'd1;
        end
        if (left_q == 3'd0 && tx_bits_q == 4'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      resp_q  <= '0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      resp_q  <= resp_d;
      left_q  <= left_d;
    end
  end

  assign wbm_cyc_o = state_q == S_BUS;
  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_we_o  = wbm_cyc_o & we_q;
  assign wbm_sel_o = {4{wbm_cyc_o}};
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign busy_o    = state_q != S_IDLE;
endmodule
